// File: rtl/mem_map_pkg.sv
// Address map, state encoding and decode bundle shared by
// the memory bridge and its address decoder.
package mem_map_pkg;

  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE = 32'h1001_0000;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

  localparam logic [3:0] OFF_CON_TX = 4'h0;
  localparam logic [3:0] OFF_CON_ST = 4'h4;
  localparam logic [3:0] OFF_CYCLE  = 4'h8;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  typedef enum logic [1:0] {
    REG_TEXT,
    REG_DATA,
    REG_MMIO,
    REG_NONE
  } region_e;

  typedef struct packed {
    region_e     region;
    logic [13:0] off;
    logic        err;
  } dec_t;

  // True when addr lies in the 2^(aw+2)-byte window at base.
  function automatic logic in_win(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int          aw
  );
    logic [31:0] mask;
    mask = (32'd1 << (aw + 2)) - 32'd1;
    return (addr & ~mask) == base;
  endfunction

endpackage

// File: rtl/mem_decode.sv
// Maps a byte address and write flag to a region, a word
// offset inside it and an access-error flag.
module mem_decode
  import mem_map_pkg::*;
#(
  parameter int TEXT_AW = 12,
  parameter int DATA_AW = 12
) (
  input  logic [31:0] addr,
  input  logic        we,
  output dec_t        dec
);

  logic text_hit;
  logic data_hit;
  logic mmio_hit;

  assign text_hit = in_win(addr, TEXT_BASE, TEXT_AW);
  assign data_hit = in_win(addr, DATA_BASE, DATA_AW);
  assign mmio_hit = (addr[31:4] == MMIO_BASE[31:4])
                 && (addr[3:2] != 2'b11);

  always_comb begin
    dec.region = REG_NONE;
    dec.off    = '0;
    dec.err    = 1'b0;
    unique case (1'b1)
      text_hit: begin
        dec.region = REG_TEXT;
        dec.off    = 14'(addr[TEXT_AW+1:2]);
      end
      data_hit: begin
        dec.region = REG_DATA;
        dec.off    = 14'(addr[DATA_AW+1:2]);
      end
      mmio_hit: begin
        dec.region = REG_MMIO;
        dec.off    = {10'd0, addr[3:0]};
      end
      default: dec.region = REG_NONE;
    endcase
    // Text is read-only from the data side.
    dec.err = (dec.region == REG_NONE)
           || (addr[1:0] != 2'b00)
           || ((dec.region == REG_TEXT) && we);
  end

endmodule

// File: rtl/mem_bridge.sv
// Memory-side stage: tracks the core's request tuple and
// sequences SRAM, console MMIO and error completions.
module mem_bridge
  import mem_map_pkg::*;
#(
  parameter int SRAM_LAT = 1,
  parameter int TEXT_AW  = 12,
  parameter int DATA_AW  = 12
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  output logic [31:0] mem_rdata,
  output logic        mem_rdy,
  output logic        bus_err,
  output logic        sram_sel,
  output logic [13:0] sram_addr,
  output logic        sram_en,
  output logic        sram_we,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready
);

  localparam logic [2:0] LAT = 3'(SRAM_LAT);

  logic [1:0]  state_q, state_d;
  logic        cap_v_q, cap_v_d;
  logic [31:0] cap_addr_q, cap_addr_d;
  logic [31:0] cap_wdata_q, cap_wdata_d;
  logic        cap_we_q, cap_we_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  dec_t dec;
  logic match;
  logic in_acc;
  logic sram_hit;
  logic mmio_ok;

  mem_decode #(
    .TEXT_AW(TEXT_AW),
    .DATA_AW(DATA_AW)
  ) u_dec (
    .addr(cap_addr_q),
    .we  (cap_we_q),
    .dec (dec)
  );

  assign match = cap_v_q
              && (cap_addr_q == mem_addr)
              && (cap_wdata_q == mem_wdata)
              && (cap_we_q == mem_we);

  assign in_acc   = (state_q == S_ACCESS);
  assign mmio_ok  = !dec.err && (dec.region == REG_MMIO);
  assign sram_hit = in_acc && !dec.err
                 && ((dec.region == REG_TEXT)
                  || (dec.region == REG_DATA));

  assign sram_en    = sram_hit && (cnt_q == 3'd0);
  assign sram_we    = sram_en && cap_we_q;
  assign sram_sel   = sram_hit && (dec.region == REG_DATA);
  assign sram_addr  = sram_hit ? dec.off : 14'd0;
  assign sram_wdata = sram_hit ? cap_wdata_q : 32'd0;

  assign con_valid = in_acc && mmio_ok && cap_we_q
                  && (dec.off[3:0] == OFF_CON_TX);
  assign con_data  = con_valid ? cap_wdata_q[7:0] : 8'd0;

  assign mem_rdy   = (state_q == S_DONE) && match;
  assign mem_rdata = rdata_q;
  assign bus_err   = err_q;

  always_comb begin
    state_d     = state_q;
    cap_v_d     = cap_v_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    cap_we_d    = cap_we_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q + 32'd1;
    rdata_d     = rdata_q;
    err_d       = err_q;
    if (!match) begin
      // A new tuple always wins, even mid-access.
      state_d     = S_ACCESS;
      cap_v_d     = 1'b1;
      cap_addr_d  = mem_addr;
      cap_wdata_d = mem_wdata;
      cap_we_d    = mem_we;
      cnt_d       = 3'd0;
    end else if (in_acc) begin
      unique case (1'b1)
        dec.err: begin
          state_d = S_DONE;
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
        end
        mmio_ok: begin
          if (cap_we_q) begin
            if (!con_valid || con_ready) state_d = S_DONE;
          end else begin
            state_d = S_DONE;
            unique case (dec.off[3:0])
              OFF_CON_ST: rdata_d = {31'd0, con_ready};
              OFF_CYCLE:  rdata_d = cyc_q;
              default:    rdata_d = 32'd0;
            endcase
          end
        end
        default: begin
          if (cnt_q == LAT) begin
            state_d = S_DONE;
            if (!cap_we_q) rdata_d = sram_rdata;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      cap_v_q     <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cap_we_q    <= 1'b0;
      cnt_q       <= '0;
      cyc_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_v_q     <= cap_v_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      cap_we_q    <= cap_we_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: one instance at SRAM_LAT=1
// and one at SRAM_LAT=3 share the core-side stimulus.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        con_ready;

  logic [31:0] r0_rdata, r3_rdata;
  logic        r0_rdy, r3_rdy;
  logic        r0_err, r3_err;
  logic        r0_sel, r3_sel;
  logic [13:0] r0_addr, r3_addr;
  logic        r0_en, r3_en;
  logic        r0_we, r3_we;
  logic [31:0] r0_wd, r3_wd;
  logic [31:0] r0_srd, r3_srd;
  logic [7:0]  r0_cd, r3_cd;
  logic        r0_cv, r3_cv;

  int n_chk = 0;
  int n_err = 0;
  int en0_n = 0;
  int en3_n = 0;

  always #5 clk = ~clk;

  mem_bridge #(.SRAM_LAT(1)) u0 (
    .clk(clk), .sys_rst_n(rst_n),
    .mem_addr(addr), .mem_wdata(wdata), .mem_we(we),
    .mem_rdata(r0_rdata), .mem_rdy(r0_rdy),
    .bus_err(r0_err), .sram_sel(r0_sel),
    .sram_addr(r0_addr), .sram_en(r0_en),
    .sram_we(r0_we), .sram_wdata(r0_wd),
    .sram_rdata(r0_srd), .con_data(r0_cd),
    .con_valid(r0_cv), .con_ready(con_ready)
  );

  mem_bridge #(.SRAM_LAT(3)) u3 (
    .clk(clk), .sys_rst_n(rst_n),
    .mem_addr(addr), .mem_wdata(wdata), .mem_we(we),
    .mem_rdata(r3_rdata), .mem_rdy(r3_rdy),
    .bus_err(r3_err), .sram_sel(r3_sel),
    .sram_addr(r3_addr), .sram_en(r3_en),
    .sram_we(r3_we), .sram_wdata(r3_wd),
    .sram_rdata(r3_srd), .con_data(r3_cd),
    .con_valid(r3_cv), .con_ready(con_ready)
  );

  // SRAM models: unwritten words have address-derived contents.
  bit   [15:0] wv0, wv3;
  logic [31:0] wm0 [16];
  logic [31:0] wm3 [16];
  logic [31:0] p0;
  logic [31:0] p3 [3];

  function automatic logic [31:0] dflt(
    input logic sel, input logic [13:0] a);
    return sel ? 32'hDA7A_0000 + {18'd0, a}
               : 32'h0000_0511 + {18'd0, a};
  endfunction

  assign r0_srd = p0;
  assign r3_srd = p3[2];

  always @(posedge clk) begin
    if (r0_en) en0_n <= en0_n + 1;
    if (r3_en) en3_n <= en3_n + 1;
    p0 <= !r0_en ? 32'd0
        : (r0_sel && wv0[r0_addr[3:0]]) ? wm0[r0_addr[3:0]]
        : dflt(r0_sel, r0_addr);
    p3[0] <= !r3_en ? 32'd0
        : (r3_sel && wv3[r3_addr[3:0]]) ? wm3[r3_addr[3:0]]
        : dflt(r3_sel, r3_addr);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    if (r0_en && r0_we && r0_sel) begin
      wv0[r0_addr[3:0]] <= 1'b1;
      wm0[r0_addr[3:0]] <= r0_wd;
    end
    if (r3_en && r3_we && r3_sel) begin
      wv3[r3_addr[3:0]] <= 1'b1;
      wm3[r3_addr[3:0]] <= r3_wd;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic req(input logic [31:0] a,
                     input logic [31:0] d,
                     input logic w);
    addr  = a;
    wdata = d;
    we    = w;
  endtask

  logic [31:0] c1;
  int          base;

  initial begin
    rst_n     = 1'b0;
    con_ready = 1'b0;
    req(32'hFFFF_0004, 32'd0, 1'b0);
    repeat (2) cyc();
    mid();
    chk("rst_rdy", {31'd0, r0_rdy}, 32'd0);
    chk("rst_rdata", r0_rdata, 32'd0);
    chk("rst_err", {31'd0, r0_err}, 32'd0);
    chk("rst_en", {30'd0, r0_en, r3_en}, 32'd0);
    chk("rst_cv", {31'd0, r0_cv}, 32'd0);
    cyc();
    rst_n = 1'b1;
    repeat (4) cyc();

    // Text read, latency 1
    req(32'h0040_0008, 32'd0, 1'b0);
    mid();
    chk("t1_rdy_T", {31'd0, r0_rdy}, 32'd0);
    cyc(); mid();
    chk("t1_en", {31'd0, r0_en}, 32'd1);
    chk("t1_sel", {31'd0, r0_sel}, 32'd0);
    chk("t1_addr", {18'd0, r0_addr}, 32'd2);
    cyc(); mid();
    chk("t1_rdy_T2", {31'd0, r0_rdy}, 32'd0);
    cyc(); mid();
    chk("t1_rdy_T3", {31'd0, r0_rdy}, 32'd1);
    chk("t1_rdata", r0_rdata, 32'h0000_0513);

    // Data write held for 10 cycles
    req(32'h1001_0004, 32'h1234_5678, 1'b1);
    base = en0_n;
    cyc(); mid();
    chk("t2_en", {31'd0, r0_en}, 32'd1);
    chk("t2_we", {31'd0, r0_we}, 32'd1);
    chk("t2_sel", {31'd0, r0_sel}, 32'd1);
    chk("t2_addr", {18'd0, r0_addr}, 32'd1);
    for (int i = 2; i <= 10; i++) begin
      cyc(); mid();
      chk("t2_rdy", {31'd0, r0_rdy}, (i >= 3) ? 32'd1 : 32'd0);
    end
    chk("t2_pulses", 32'(en0_n - base), 32'd1);
    chk("t2_mem", wm0[1], 32'h1234_5678);

    // Console write stalled by con_ready
    req(32'hFFFF_0000, 32'h0000_0041, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      cyc(); mid();
      chk("t3_cv", {31'd0, r0_cv}, 32'd1);
      chk("t3_cd", {24'd0, r0_cd}, 32'h41);
      chk("t3_rdy", {31'd0, r0_rdy}, 32'd0);
    end
    cyc();
    con_ready = 1'b1;
    mid();
    chk("t3_rdy_hs", {31'd0, r0_rdy}, 32'd0);
    cyc(); mid();
    chk("t3_rdy_done", {31'd0, r0_rdy}, 32'd1);
    chk("t3_cv_done", {31'd0, r0_cv}, 32'd0);
    cyc();
    con_ready = 1'b0;

    // Errors: text write, MMIO read, unmapped, misaligned
    mid();
    chk("t4_err_pre", {31'd0, r0_err}, 32'd0);
    req(32'h0040_0000, 32'h0000_0055, 1'b1);
    cyc(); mid();
    chk("t4_en", {31'd0, r0_en}, 32'd0);
    chk("t4_rdy_T1", {31'd0, r0_rdy}, 32'd0);
    cyc(); mid();
    chk("t4_rdy", {31'd0, r0_rdy}, 32'd1);
    chk("t4_rdata", r0_rdata, 32'hDEAD_BEEF);
    chk("t4_err", {31'd0, r0_err}, 32'd1);
    req(32'hFFFF_0004, 32'd0, 1'b0);
    cyc(); cyc(); mid();
    chk("t4_st_rdy", {31'd0, r0_rdy}, 32'd1);
    chk("t4_st", r0_rdata, 32'd0);
    req(32'h2000_0000, 32'd0, 1'b0);
    cyc(); cyc(); mid();
    chk("t4_um_rdy", {31'd0, r0_rdy}, 32'd1);
    chk("t4_um", r0_rdata, 32'hDEAD_BEEF);
    chk("t4_sticky", {31'd0, r0_err}, 32'd1);
    req(32'hFFFF_0004, 32'd0, 1'b0);
    cyc(); cyc(); mid();
    chk("t4_st2", r0_rdata, 32'd0);
    req(32'h1001_0002, 32'd0, 1'b0);
    cyc(); mid();
    chk("t4_mis_en", {30'd0, r0_en, r3_en}, 32'd0);
    cyc(); mid();
    chk("t4_mis", r0_rdata, 32'hDEAD_BEEF);
    cyc();

    // Tuple change one cycle into ACCESS, latency 3
    req(32'h1001_0000, 32'd0, 1'b0);
    base = en3_n;
    cyc(); mid();
    chk("t5_en1", {31'd0, r3_en}, 32'd1);
    chk("t5_addr1", {18'd0, r3_addr}, 32'd0);
    cyc();
    req(32'h1001_0010, 32'd0, 1'b0);
    cyc(); mid();
    chk("t5_en2", {31'd0, r3_en}, 32'd1);
    chk("t5_addr2", {18'd0, r3_addr}, 32'd4);
    for (int i = 4; i <= 6; i++) begin
      cyc(); mid();
      chk("t5_rdy", {31'd0, r3_rdy}, 32'd0);
      chk("t5_hold", r3_rdata, 32'hDEAD_BEEF);
    end
    cyc(); mid();
    chk("t5_rdy_T7", {31'd0, r3_rdy}, 32'd1);
    chk("t5_rdata", r3_rdata, 32'hDA7A_0004);
    chk("t5_pulses", 32'(en3_n - base), 32'd2);

    // Cycle counter, 10 cycles apart
    req(32'hFFFF_0008, 32'd0, 1'b0);
    cyc(); cyc(); mid();
    chk("t6_rdy1", {31'd0, r0_rdy}, 32'd1);
    c1 = r0_rdata;
    cyc();
    req(32'hFFFF_0004, 32'd0, 1'b0);
    repeat (7) cyc();
    req(32'hFFFF_0008, 32'd0, 1'b0);
    cyc(); cyc(); mid();
    chk("t6_rdy2", {31'd0, r0_rdy}, 32'd1);
    chk("t6_delta", r0_rdata - c1, 32'd10);

    // Reset in the middle of an SRAM access
    cyc();
    req(32'h1001_0000, 32'd0, 1'b0);
    cyc(); mid();
    chk("t7_en_pre", {31'd0, r0_en}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_en", {30'd0, r0_en, r3_en}, 32'd0);
    chk("t7_rdy", {30'd0, r0_rdy, r3_rdy}, 32'd0);
    chk("t7_rdata", r0_rdata, 32'd0);
    chk("t7_err", {30'd0, r0_err, r3_err}, 32'd0);
    chk("t7_addr", {18'd0, r0_addr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
